// File: rtl/multiplier_pkg.sv
// Shared constants and types for the multiplier built-in self-test.
package multiplier_pkg;

    localparam int WIDTH = 4;
    localparam int P_W   = 2*WIDTH + 1;
    localparam int ACC_W = 2*WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_e;

    // The step counter must hold WIDTH itself, because it increments once more after the last step.
    function automatic int step_w(input int w);
        return (w < 2) ? 1 : $clog2(w + 1);
    endfunction

endpackage

// File: rtl/multiplier_bist_shift_add_ref.sv
// Sequential shift-add golden multiplier: one partial product per enabled cycle.
module shift_add_ref #(
    parameter int WIDTH = multiplier_pkg::WIDTH
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       clr,
    input  logic                                       en,
    input  logic [WIDTH-1:0]                           a,
    input  logic [WIDTH-1:0]                           b,
    output logic [multiplier_pkg::step_w(WIDTH)-1:0]   step,
    output logic [2*WIDTH-1:0]                         acc
);

    import multiplier_pkg::*;

    localparam int ACC_BITS = 2*WIDTH;

    logic [ACC_BITS-1:0] w_addend;

    assign w_addend = b[step] ? ({{WIDTH{1'b0}}, a} << step) : '0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc  <= '0;
            step <= '0;
        end else if (clr) begin
            acc  <= '0;
            step <= '0;
        end else if (en) begin
            acc  <= acc + w_addend;
            step <= step + 1'b1;
        end
    end

endmodule

// File: rtl/multiplier_bist.sv
// Exhaustive self-test sweep for the combinational multiplier: drives every
// operand pair, checks p against a shift-add golden product, records errors.
module multiplier_bist #(
    parameter int WIDTH = multiplier_pkg::WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [WIDTH-1:0]   a,
    output logic [WIDTH-1:0]   b,
    input  logic [2*WIDTH:0]   p,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH:0]   err_count,
    output logic               fail_valid,
    output logic [WIDTH-1:0]   fail_a,
    output logic [WIDTH-1:0]   fail_b
);

    import multiplier_pkg::*;

    localparam int                STEP_W    = step_w(WIDTH);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(WIDTH - 1);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_fail_a;
    logic [WIDTH-1:0]   r_fail_b;
    logic [2*WIDTH:0]   r_err_count;
    logic               r_fail_valid;

    logic [STEP_W-1:0]  w_step;
    logic [2*WIDTH-1:0] w_acc;
    logic               w_start_ok;
    logic               w_last_pair;
    logic               w_check;
    logic               w_mismatch;
    logic               w_clr;
    logic               w_en;

    assign w_start_ok  = start && (r_state == IDLE || r_state == DONE);
    assign w_last_pair = (&r_a) && (&r_b);
    assign w_check     = (r_state == CHECK);
    // Zero-extending the golden value makes any set bit above the product range a mismatch.
    assign w_mismatch  = (p != {1'b0, w_acc});
    assign w_clr       = w_start_ok || (w_check && !w_last_pair);
    assign w_en        = (r_state == CALC);

    shift_add_ref #(
        .WIDTH (WIDTH)
    ) u_ref (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_clr),
        .en   (w_en),
        .a    (r_a),
        .b    (r_b),
        .step (w_step),
        .acc  (w_acc)
    );

    // NOTE: always_comb assigns a default first so no path leaves the next state unassigned (no latch).
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start_ok) w_state_nxt = CALC;
            CALC:    if (w_step == LAST_STEP) w_state_nxt = CHECK;
            CHECK:   w_state_nxt = w_last_pair ? DONE : CALC;
            DONE:    if (w_start_ok) w_state_nxt = CALC;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_a          <= '0;
            r_b          <= '0;
            r_err_count  <= '0;
            r_fail_valid <= 1'b0;
            r_fail_a     <= '0;
            r_fail_b     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_ok) begin
                r_a          <= '0;
                r_b          <= '0;
                r_err_count  <= '0;
                r_fail_valid <= 1'b0;
                r_fail_a     <= '0;
                r_fail_b     <= '0;
            end else if (w_check) begin
                if (w_mismatch) begin
                    r_err_count <= r_err_count + 1'b1;
                    if (!r_fail_valid) begin
                        r_fail_valid <= 1'b1;
                        r_fail_a     <= r_a;
                        r_fail_b     <= r_b;
                    end
                end
                // b is the low half, so its wrap carries into a.
                if (!w_last_pair) begin
                    {r_a, r_b} <= {r_a, r_b} + 1'b1;
                end
            end
        end
    end

    assign a          = r_a;
    assign b          = r_b;
    assign busy       = (r_state == CALC) || (r_state == CHECK);
    assign done       = (r_state == DONE);
    assign pass       = done && (r_err_count == '0);
    assign err_count  = r_err_count;
    assign fail_valid = r_fail_valid;
    assign fail_a     = r_fail_a;
    assign fail_b     = r_fail_b;

endmodule

// File: tb/tb_multiplier_bist.sv
// Directed bench for multiplier_bist with a faultable behavioural multiplier.
module tb_multiplier_bist;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic [8:0] p;
    logic       busy;
    logic       done;
    logic       pass;
    logic [8:0] err_count;
    logic       fail_valid;
    logic [3:0] fail_a;
    logic [3:0] fail_b;

    int fault_mode;
    int n_checks;
    int n_fail;
    int n_cyc;

    multiplier_bist #(
        .WIDTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .p          (p),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .fail_valid (fail_valid),
        .fail_a     (fail_a),
        .fail_b     (fail_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural multiplier: 0 good, 1 p[0] stuck-0, 2 p[8] stuck-1, 3 wrong only at 15*15.
    always_comb begin
        p = {5'b0, a} * {5'b0, b};
        case (fault_mode)
            1:       p[0] = 1'b0;
            2:       p[8] = 1'b1;
            3:       if (a == 4'd15 && b == 4'd15) p = p ^ 9'd1;
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic start_sweep();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic advance(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (!done && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        fault_mode = 0;
        start      = 1'b0;
        rst        = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_a", a, 0);
        check("rst_b", b, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err_count, 0);
        check("rst_fvalid", fail_valid, 0);
        @(negedge clk);
        rst = 1'b0;

        // Good multiplier, with sweep-order spot checks.
        start_sweep();
        check("busy_after_start", busy, 1);
        check("first_pair", {a, b}, 8'h00);
        advance(5);
        check("second_pair", {a, b}, 8'h01);
        advance(75);
        check("pair_a1_b0", {a, b}, 8'h10);
        wait_done(80, n_cyc);
        check("good_cycles", n_cyc, 1280);
        check("good_pass", pass, 1);
        check("good_busy_low", busy, 0);
        check("good_err", err_count, 0);
        check("good_fvalid", fail_valid, 0);

        // p[0] stuck at 0: fails whenever both operands are odd.
        fault_mode = 1;
        start_sweep();
        wait_done(0, n_cyc);
        check("lsb_cycles", n_cyc, 1280);
        check("lsb_err", err_count, 64);
        check("lsb_fail_a", fail_a, 1);
        check("lsb_fail_b", fail_b, 1);
        check("lsb_pass", pass, 0);
        check("lsb_fvalid", fail_valid, 1);

        // Top bit stuck at 1: every pair fails.
        fault_mode = 2;
        start_sweep();
        wait_done(0, n_cyc);
        check("msb_err", err_count, 256);
        check("msb_fail_ab", {fail_a, fail_b}, 8'h00);
        check("msb_pass", pass, 0);

        // Second start at cycle 300 is ignored.
        fault_mode = 0;
        start_sweep();
        check("restart_clears_err", err_count, 0);
        advance(299);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("restart_busy", busy, 1);
        wait_done(300, n_cyc);
        check("restart_cycles", n_cyc, 1280);
        check("restart_pass", pass, 1);

        // Asynchronous reset at cycle 700; 140 pairs done, 32 odd*odd fails so far.
        fault_mode = 1;
        start_sweep();
        advance(700);
        check("pre_rst_err", err_count, 32);
        check("pre_rst_ab", {a, b}, 8'h8C);
        rst = 1'b1;
        #1;
        check("mid_rst_a", a, 0);
        check("mid_rst_b", b, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_err", err_count, 0);
        @(negedge clk);
        rst = 1'b0;
        advance(3);
        check("idle_after_rst", {busy, done}, 0);
        start_sweep();
        wait_done(0, n_cyc);
        check("post_rst_cycles", n_cyc, 1280);
        check("post_rst_err", err_count, 64);

        // Only the final pair is wrong; caught on the edge entering DONE.
        fault_mode = 3;
        start_sweep();
        advance(1279);
        check("last_pre_err", err_count, 0);
        check("last_pre_busy", busy, 1);
        check("last_pre_ab", {a, b}, 8'hFF);
        wait_done(1279, n_cyc);
        check("last_cycles", n_cyc, 1280);
        check("last_err", err_count, 1);
        check("last_fail_ab", {fail_a, fail_b}, 8'hFF);
        check("last_pass", pass, 0);
        check("last_done", done, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multiplier_bist.md
# multiplier_bist

Built-in self-test sequencer that sits directly upstream of the combinational carry-save `multiplier`. It drives the multiplier's `a`/`b` operands through every operand pair and computes a golden product with an internal sequential shift-add engine. It compares each golden product against the multiplier's `p` and reports pass/fail, an error count and the first failing pair. This gives on-chip, exhaustive coverage equivalent to the simulation sweep.

## Interface
- `WIDTH`, default 4: operand width; the multiplier port `p` is `2*WIDTH+1` bits.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: single-cycle pulse that begins a sweep; ignored while `busy`.
- `a`  out  WIDTH: operand A to the multiplier (registered).
- `b`  out  WIDTH: operand B to the multiplier (registered).
- `p`  in  2*WIDTH+1: product returned by the multiplier.
- `busy`  out  1: high from the cycle after `start` is accepted until DONE is entered.
- `done`  out  1: high while in DONE.
- `pass`  out  1: `done && err_count == 0`.
- `err_count`  out  2*WIDTH+1: number of mismatching pairs (max 2^(2*WIDTH), no saturation needed).
- `fail_valid`  out  1: at least one mismatch recorded.
- `fail_a`, `fail_b`  out  WIDTH each: operands of the first mismatch.

## Operation
- FSM states:
  - IDLE, CALC, CHECK, DONE.
  - Reset forces IDLE.
  - Reset values: all outputs 0, internal accumulator 0, step counter 0.
- IDLE / DONE with `start` = 1:
  - Clear `a`, `b`, the accumulator, the step counter, `err_count`, `fail_valid`, `fail_a` and `fail_b`.
  - Go to CALC.
- CALC: runs exactly WIDTH cycles, step i = 0..WIDTH-1.
  - If `b[i]` = 1, add `a << i` to the 2*WIDTH-bit accumulator.
  - After step WIDTH-1, go to CHECK.
- CHECK: one cycle.
  - Compare `p` against the zero-extended accumulator.
  - On mismatch, increment `err_count`.
  - If `fail_valid` = 0, latch `fail_a`/`fail_b` from `a`/`b` and set `fail_valid`.
- After CHECK:
  - If `a` and `b` are both all-ones, go to DONE.
  - Otherwise advance the pair: `b` increments first; on `b` wrap to 0, `a` increments. Clear the accumulator and step counter, then go to CALC.
  - Sweep order is a=0,b=0..max, then a=1, …
- DONE: holds all results until `start` or `rst`.
- `start` while in CALC/CHECK: ignored, no restart.
- `a`/`b` change only on the CHECK→CALC transition or on `start`. They are therefore stable for WIDTH+1 cycles before `p` is sampled, which covers the combinational multiplier's settle time.
- Any bit of `p` above bit 2*WIDTH-1 (including the top bit) must be 0. A nonzero value there counts as a mismatch.

## Timing
- Per pair: WIDTH+1 cycles (WIDTH=4: 5).
- Full sweep: 2^(2*WIDTH)·(WIDTH+1) cycles from the edge that samples `start` to the edge entering DONE (WIDTH=4: 1280).
- `busy` rises on the edge that samples `start`. It falls, and `done` rises, on the same edge (the one entering DONE).
- `err_count` and `fail_*` update on the edge leaving CHECK.
- `rst` mid-sweep: all outputs return to their reset values asynchronously; FSM goes to IDLE; the next sweep requires a fresh `start`.

## Structure
- Package `multiplier_pkg`:
  - `WIDTH` default constant.
  - State enum typedef (IDLE, CALC, CHECK, DONE).
  - Derived widths `P_W = 2*WIDTH+1` and `ACC_W = 2*WIDTH`.
- Sub-module `shift_add_ref`:
  - Sequential golden multiplier.
  - Ports: `clk`, `rst`, `clr`, `en`, `a`, `b`, `step`, `acc`.
- The top level contains the FSM, pair counter and result registers.

## Test plan
- Correct `multiplier` connected, single `start` → `done` and `pass` = 1 exactly 1280 cycles later, `err_count` = 0, `fail_valid` = 0.
- Model with `p[0]` stuck at 0 → `err_count` = 64 (both operands odd), `fail_a` = 1, `fail_b` = 1, `pass` = 0.
- Model with top bit `p[8]` stuck at 1 → `err_count` = 256, first fail (0,0).
- `start` pulsed again at cycle 300 of a sweep → ignored; `done` still asserts at cycle 1280 with unchanged results.
- `rst` asserted at cycle 700 → `a`, `b`, `busy`, `err_count` immediately 0; a new `start` completes a full sweep in 1280 cycles.
- Model wrong only for a=15,b=15 → `err_count` = 1, `fail_a` = 15, `fail_b` = 15, detected in the final CHECK immediately before DONE.
